// File: rtl/apb_req_arbiter_if.sv
// rtl/apb_req_arbiter_if.sv - requester and apb_wrapper-side bundle for apb_req_arbiter
interface apb_req_arbiter_if #(
    parameter int addr_width = 5,
    parameter int data_width = 16,
    parameter int num_req    = 4
);
    logic [num_req-1:0]            req_valid;
    logic [num_req-1:0]            req_write;
    logic [num_req*addr_width-1:0] req_addr;
    logic [num_req*data_width-1:0] req_wdata;
    logic [num_req-1:0]            req_ready;
    logic [num_req-1:0]            rsp_valid;
    logic [data_width-1:0]         rsp_rdata;
    logic                          busy;
    logic                          transfer;
    logic [addr_width-1:0]         apb_paddr;
    logic [data_width-1:0]         apb_pwdata;
    logic                          apb_control;
    logic [data_width-1:0]         apb_prdata;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, apb_prdata,
        output req_ready, rsp_valid, rsp_rdata, busy, transfer,
               apb_paddr, apb_pwdata, apb_control
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata, apb_prdata,
        input  req_ready, rsp_valid, rsp_rdata, busy, transfer,
               apb_paddr, apb_pwdata, apb_control
    );
endinterface

// File: rtl/apb_req_arbiter.sv
// rtl/apb_req_arbiter.sv - round-robin multi-requester sequencer for apb_wrapper (APB_ARB_FIXED_PRIO_EN: fixed priority)
module apb_req_arbiter #(
    parameter int addr_width  = 5,
    parameter int data_width  = 16,
    parameter int num_req     = 4,
    parameter int xfer_cycles = 3
) (
    input  logic               pclk,
    input  logic               preset_n,
    apb_req_arbiter_if.slave   bus
);
    localparam int gw = $clog2(num_req);
    localparam int iw = gw + 1;
    localparam int cw = $clog2(xfer_cycles);

    if (xfer_cycles < 2) begin : g_bad_xfer_cycles
        $error("apb_req_arbiter: xfer_cycles must be >= 2");
    end
    if (num_req < 2 || num_req > 8) begin : g_bad_num_req
        $error("apb_req_arbiter: num_req must be in 2..8");
    end

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    state_t                state_q, state_d;
    logic [gw-1:0]         last_grant;
    logic [gw-1:0]         winner;
    logic                  found;
    logic                  accept;
    logic [cw-1:0]         cnt_q;
    logic [num_req-1:0]    req_ready_c;
    logic [num_req-1:0]    rsp_valid_q;
    logic [addr_width-1:0] paddr_q;
    logic [data_width-1:0] pwdata_q;
    logic [data_width-1:0] rdata_q;
    logic                  control_q;

`ifdef APB_ARB_FIXED_PRIO_EN
    // Descending scan so the lowest valid index is the last one written.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = num_req - 1; k >= 0; k--) begin
            if (bus.req_valid[gw'(k)]) begin
                found  = 1'b1;
                winner = gw'(k);
            end
        end
    end
`else
    // Scan starts one past the previous winner and wraps at num_req.
    always_comb begin
        logic [iw-1:0] idx;
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = 0; k < num_req; k++) begin
            idx = {1'b0, last_grant} + iw'(k + 1);
            if (idx >= iw'(num_req)) idx = idx - iw'(num_req);
            if (!found && bus.req_valid[idx[gw-1:0]]) begin
                found  = 1'b1;
                winner = idx[gw-1:0];
            end
        end
    end
`endif

    assign accept = (state_q == IDLE) && found;

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) state_q <= IDLE;
        else           state_q <= state_d;
    end

    // req_ready is gated by reset so nothing is offered while the block is held.
    always_comb begin
        state_d     = state_q;
        req_ready_c = '0;
        case (state_q)
            IDLE: begin
                if (found && preset_n) begin
                    req_ready_c[winner] = 1'b1;
                    state_d             = XFER;
                end
            end
            XFER:    if (cnt_q == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            last_grant  <= gw'(num_req - 1);
            cnt_q       <= '0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            control_q   <= 1'b0;
            rdata_q     <= '0;
            rsp_valid_q <= '0;
        end else begin
            rsp_valid_q <= '0;
            if (accept) begin
                paddr_q    <= bus.req_addr[int'(winner) * addr_width +: addr_width];
                pwdata_q   <= bus.req_wdata[int'(winner) * data_width +: data_width];
                control_q  <= bus.req_write[winner];
                cnt_q      <= cw'(xfer_cycles - 1);
                last_grant <= winner;
            end else if (state_q == XFER) begin
                if (cnt_q != '0) begin
                    cnt_q <= cnt_q - 1'b1;
                end else begin
                    if (!control_q) rdata_q <= bus.apb_prdata;
                    rsp_valid_q[last_grant] <= 1'b1;
                end
            end
        end
    end

    assign bus.req_ready   = req_ready_c;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rdata_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.transfer    = (state_q == XFER);
    assign bus.apb_paddr   = paddr_q;
    assign bus.apb_pwdata  = pwdata_q;
    assign bus.apb_control = control_q;
endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb/tb_apb_req_arbiter.sv - directed scoreboard bench for apb_req_arbiter
module tb_apb_req_arbiter;
    logic pclk;
    logic preset_n;

    apb_req_arbiter_if #(.addr_width(5), .data_width(16), .num_req(4)) bus ();

    apb_req_arbiter #(
        .addr_width(5), .data_width(16), .num_req(4), .xfer_cycles(3)
    ) dut (
        .pclk(pclk),
        .preset_n(preset_n),
        .bus(bus)
    );

    typedef struct {
        logic [3:0]  rsp;
        logic [15:0] rdata;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [4:0]  a[4];
    logic [15:0] d[4];
    logic        wr[4];
    logic [15:0] rdata_m;
    logic [15:0] pr_val;
    logic [4:0]  last_addr;

    always_comb bus.req_addr  = {a[3], a[2], a[1], a[0]};
    always_comb bus.req_wdata = {d[3], d[2], d[1], d[0]};
    always_comb bus.req_write = {wr[3], wr[2], wr[1], wr[0]};

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    initial begin
        #200us;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with inputs already applied; returns at the negedge of cycle xfer_cycles+2.
    task automatic run_txn(input int w);
        exp_t        e;
        exp_t        g;
        logic [4:0]  la;
        logic [15:0] ld;
        logic        lc;
        #1;
        check($sformatf("req_ready_w%0d", w), {28'b0, bus.req_ready}, 32'(4'b0001 << w));
        la = a[w];
        ld = d[w];
        lc = wr[w];
        last_addr = la;
        if (!lc) rdata_m = pr_val;
        e.rsp   = 4'b0001 << w;
        e.rdata = rdata_m;
        sb.push_back(e);
        @(posedge pclk);
        for (int c = 1; c <= 3; c++) begin
            @(negedge pclk);
            if (!lc) bus.apb_prdata = (c == 3) ? pr_val : ~pr_val;
            check("transfer_hi", {31'b0, bus.transfer}, 32'd1);
            check("apb_paddr", {27'b0, bus.apb_paddr}, {27'b0, la});
            check("apb_pwdata", {16'b0, bus.apb_pwdata}, {16'b0, ld});
            check("apb_control", {31'b0, bus.apb_control}, {31'b0, lc});
            check("ready_in_xfer", {28'b0, bus.req_ready}, 32'd0);
            if (c == 1) begin
                a[w] = ~la;
                d[w] = ~ld;
            end
        end
        @(negedge pclk);
        if (!lc) bus.apb_prdata = 16'hDEAD;
        check("transfer_done", {31'b0, bus.transfer}, 32'd0);
        check("busy_done", {31'b0, bus.busy}, 32'd1);
        check("sb_nonempty", {31'b0, (sb.size() > 0)}, 32'd1);
        if (sb.size() > 0) begin
            g = sb.pop_front();
            check("rsp_valid", {28'b0, bus.rsp_valid}, {28'b0, g.rsp});
            check("rsp_rdata", {16'b0, bus.rsp_rdata}, {16'b0, g.rdata});
        end
        @(negedge pclk);
        check("rsp_pulse_end", {28'b0, bus.rsp_valid}, 32'd0);
        check("transfer_gap", {31'b0, bus.transfer}, 32'd0);
        check("rdata_hold", {16'b0, bus.rsp_rdata}, {16'b0, rdata_m});
        pr_val = pr_val + 16'h1111;
    endtask

    initial begin
        int order[5];
`ifdef APB_ARB_FIXED_PRIO_EN
        order = '{0, 0, 0, 0, 0};
`else
        order = '{0, 1, 2, 3, 0};
`endif
        a[0] = 5'h03; d[0] = 16'hA5A5; wr[0] = 1'b1;
        a[1] = 5'h0A; d[1] = 16'h1111; wr[1] = 1'b1;
        a[2] = 5'h1F; d[2] = 16'h5A5A; wr[2] = 1'b0;
        a[3] = 5'h15; d[3] = 16'h3C3C; wr[3] = 1'b1;
        rdata_m         = 16'h0000;
        pr_val          = 16'h1234;
        last_addr       = 5'h00;
        bus.apb_prdata  = 16'h1234;
        bus.req_valid   = 4'b1111;
        preset_n        = 1'b0;

        #100;
        check("rst_transfer", {31'b0, bus.transfer}, 32'd0);
        check("rst_busy", {31'b0, bus.busy}, 32'd0);
        check("rst_control", {31'b0, bus.apb_control}, 32'd0);
        check("rst_paddr", {27'b0, bus.apb_paddr}, 32'd0);
        check("rst_pwdata", {16'b0, bus.apb_pwdata}, 32'd0);
        check("rst_rdata", {16'b0, bus.rsp_rdata}, 32'd0);
        check("rst_rsp_valid", {28'b0, bus.rsp_valid}, 32'd0);
        check("rst_req_ready", {28'b0, bus.req_ready}, 32'd0);

        @(negedge pclk);
        preset_n = 1'b1;
        for (int i = 0; i < 5; i++) run_txn(order[i]);

        bus.req_valid = 4'b1110;
        run_txn(1);
        bus.req_valid = 4'b1000;
        run_txn(3);
        bus.req_valid = 4'b1001;
        run_txn(0);
`ifdef APB_ARB_FIXED_PRIO_EN
        run_txn(0);
`else
        run_txn(3);
`endif

        bus.req_valid = 4'b0000;
        #1;
        check("idle_ready", {28'b0, bus.req_ready}, 32'd0);
        check("idle_busy", {31'b0, bus.busy}, 32'd0);
        @(negedge pclk);
        check("idle_transfer", {31'b0, bus.transfer}, 32'd0);
        check("idle_paddr_hold", {27'b0, bus.apb_paddr}, {27'b0, last_addr});

        bus.req_valid = 4'b0001;
        #1;
        check("mid_ready", {28'b0, bus.req_ready}, 32'd1);
        @(posedge pclk);
        @(negedge pclk);
        check("mid_transfer_c1", {31'b0, bus.transfer}, 32'd1);
        @(posedge pclk);
        #2;
        preset_n = 1'b0;
        #1;
        check("mid_transfer_drop", {31'b0, bus.transfer}, 32'd0);
        check("mid_busy_drop", {31'b0, bus.busy}, 32'd0);
        check("mid_rsp_valid", {28'b0, bus.rsp_valid}, 32'd0);
        check("mid_rdata_rst", {16'b0, bus.rsp_rdata}, 32'd0);
        rdata_m = 16'h0000;
        for (int i = 0; i < 2; i++) begin
            @(negedge pclk);
            check("mid_no_rsp", {28'b0, bus.rsp_valid}, 32'd0);
        end
        preset_n = 1'b1;
        run_txn(0);

        bus.req_valid = 4'b0000;
        repeat (3) @(negedge pclk);
        check("sb_drained", sb.size(), 32'd0);
        check("final_rsp_valid", {28'b0, bus.rsp_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/apb_req_arbiter.md
# apb_req_arbiter

Multi-requester front end for `apb_wrapper`. It arbitrates between `num_req` independent requesters, latches the winner's address, data and direction, and sequences one transfer at a time on the wrapper's `transfer`/`apb_*` inputs. It captures `apb_prdata` on completion and returns a per-requester response pulse. It sits directly above `apb_wrapper` and owns all of its control inputs.

## Interface
- `addr_width`, 5: APB address width; must match the `apb_wrapper` instance.
- `data_width`, 16: APB data width; must match the `apb_wrapper` instance.
- `num_req`, 4: number of requesters, legal range 2..8.
- `xfer_cycles`, 3: cycles `transfer` is held high per transaction, covering SETUP plus ACCESS with zero-wait slaves. Must be ≥2; smaller values are an elaboration error.

Ports:
- `pclk`  in  1  clock, rising edge.
- `preset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  num_req  per-requester request; held until accepted.
- `req_write`  in  num_req  1 = write, 0 = read.
- `req_addr`  in  num_req*addr_width  requester i at `[i*addr_width +: addr_width]`.
- `req_wdata`  in  num_req*data_width  requester i at `[i*data_width +: data_width]`.
- `req_ready`  out  num_req  one-hot accept strobe (combinational).
- `rsp_valid`  out  num_req  one-hot, one-cycle completion pulse (registered).
- `rsp_rdata`  out  data_width  read data for the last completed read.
- `busy`  out  1  high in XFER and DONE.
- `transfer`  out  1  to `apb_wrapper`.
- `apb_paddr`  out  addr_width  to `apb_wrapper`.
- `apb_pwdata`  out  data_width  to `apb_wrapper`.
- `apb_control`  out  1  to `apb_wrapper`; 1 = write.
- `apb_prdata`  in  data_width  from `apb_wrapper`.

## Operation
- **States.** IDLE, XFER, DONE.
- **IDLE.**
  - If any `req_valid` is high, select the winner w by round-robin.
  - The search starts at index `last_grant+1` (mod num_req), with the lowest index scanned first from that point.
  - Assert `req_ready[w]` combinationally in that cycle.
  - At the clock edge, latch `req_addr[w]`, `req_wdata[w]` and `req_write[w]` into `apb_paddr`, `apb_pwdata` and `apb_control`. Load the counter with `xfer_cycles-1`, set `last_grant` to w, and go to XFER.
- **XFER.**
  - `transfer` is 1, and `apb_*` are stable from the latched registers.
  - The counter decrements each cycle.
  - At counter==0: if it is a read, capture `apb_prdata` into `rsp_rdata`. Clear `transfer`, set `rsp_valid[w]`, and go to DONE.
- **DONE.**
  - `transfer` is 0 and `rsp_valid[w]` is 1 for exactly this cycle; then go to IDLE.
  - This guarantees at least one idle cycle of `transfer` between transactions, so the wrapper returns to its IDLE state.
- **Write completion.** A write completes with `rsp_valid` but leaves `rsp_rdata` unchanged.
- **No request pending.** Outputs hold their values, and `req_ready` is all zero.
- **New requests during XFER/DONE.** They wait. `req_ready` is only ever asserted in IDLE.
- **Payload stability.** Payload changes after acceptance do not affect the in-flight transfer.
- **Simultaneous requests.** Exactly one grant is issued. A requester cannot win twice in a row while any other requester is valid.
- **Pointer wrap-around.** `last_grant = num_req-1` wraps the search start to index 0.
- **Counter width.** `$clog2(xfer_cycles)`; the counter never underflows.

## Timing
- **Reset values (asynchronous).**
  - State: IDLE.
  - `transfer`, `apb_control`, `busy`: 0.
  - `apb_paddr`, `apb_pwdata`, `rsp_rdata`: 0.
  - `rsp_valid`: 0.
  - `last_grant`: `num_req-1`, so requester 0 wins first.
- **Cycle numbering.** Acceptance edge = cycle 0.
- **`transfer`.** High in cycles 1..`xfer_cycles`.
- **Read capture.** `apb_prdata` is sampled at the end of cycle `xfer_cycles`.
- **`rsp_valid`.** High in cycle `xfer_cycles+1`.
- **Throughput.** The earliest next `req_ready` is cycle `xfer_cycles+2`, giving `xfer_cycles+2` cycles per transaction (5 at defaults).
- **Reset mid-operation.**
  - `transfer` drops immediately and the transaction is abandoned.
  - No `rsp_valid` is issued.
  - The requester must re-request after reset.

## Configuration
- `APB_ARB_FIXED_PRIO_EN`.
  - Defined: fixed priority. The lowest valid index always wins; `last_grant` is still tracked but ignored, so starvation of high indices is permitted.
  - Undefined (default): round-robin as described above.

## Test plan
- **Reset.** Hold `preset_n`=0 for 100 ns with `req_valid`=4'b1111 -> all outputs 0, `req_ready`=0. After release, requester 0 is granted first.
- **Single write.** Requester 0 writes addr 5'h03, data 16'hA5A5 -> `req_ready[0]` for 1 cycle. `transfer`=1 for exactly 3 cycles with `apb_paddr`=5'h03, `apb_pwdata`=16'hA5A5, `apb_control`=1. Then `rsp_valid`=4'b0001 for 1 cycle, and `rsp_rdata` is unchanged.
- **Read.** Requester 2 reads addr 5'h1F while the bench drives `apb_prdata`=16'h1234 -> `apb_control`=0. `rsp_valid`=4'b0100 with `rsp_rdata`=16'h1234.
- **Round-robin under load.** All four requesters held valid -> grant order 0,1,2,3,0, accepts 5 cycles apart, `transfer` low exactly 2 cycles between bursts.
- **Fixed priority.** With `APB_ARB_FIXED_PRIO_EN`, all four held valid -> grants 0,0,0… Drop requester 0 -> requester 1 is granted next.
- **Reset mid-transfer.** Assert reset in the 2nd `transfer` cycle -> `transfer`=0 immediately and no `rsp_valid`. After release, the pending `req_valid[0]` is re-accepted first.
